uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmit queue among NUM_REQ core-side requesters in the multicore processor. Grants are whole messages, so bytes from different cores never interleave on TX. Arbitration is round-robin. A granted requester that stalls is released by a watchdog. The block drives the UART transmitter's trmt/tx_data write port and obeys its queue_full backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 50000, idle cycles with grant held and no byte accepted before forced release (1..65535; the counter is fixed at 16 bits)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester level request; held for the whole message
vld  input  NUM_REQ  per-requester byte-valid
eom  input  NUM_REQ  per-requester end-of-message flag, qualified by vld
wdata  input  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i]
gnt  output  NUM_REQ  one-hot registered grant
ack  output  NUM_REQ  per-requester byte accepted this cycle (combinational)
timeout_err  output  1  one-cycle pulse when the watchdog releases a grant
busy  output  1  high while in GRANT state
trmt  output  1  write strobe to the UART transmit queue (combinational)
tx_data  output  8  byte to the UART transmit queue
queue_full  input  1  UART transmit queue full

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, last=NUM_REQ-1 (requester 0 has top priority first), wd_cnt=0, timeout_err=0, busy=0. trmt=0 and ack=0 follow from gnt=0. Reset mid-message drops the grant; bytes already in the UART queue are unaffected.
- States: IDLE and GRANT.
- IDLE:
  - If req != 0, pick the first requester with req set, searching circularly from last+1.
  - Next cycle: gnt is one-hot for the winner, state=GRANT, wd_cnt=0.
  - Otherwise remain in IDLE.
- GRANT (winner g):
  - accept = gnt[g] & vld[g] & ~queue_full.
  - trmt = accept; ack[g] = accept; tx_data = wdata byte g. Zero latency from vld to trmt.
  - tx_data equals the granted requester's byte whenever gnt != 0, and 0 when gnt == 0.
  - ack and trmt are never asserted for a non-granted requester.
- GRANT exit conditions, evaluated in this priority order:
  1. accept & eom[g]: the last byte is written this cycle; next cycle gnt=0, state=IDLE, last=g.
  2. req[g]==0 (abort): no byte is accepted this cycle even if vld is high; next cycle gnt=0, IDLE, last=g.
  3. wd_cnt==TIMEOUT-1 with no accept this cycle: next cycle gnt=0, IDLE, last=g, timeout_err=1 for one cycle.
- Watchdog: wd_cnt clears on every accept and counts every other GRANT cycle. It does not count in IDLE. queue_full stalls count toward timeout.
- Minimum one IDLE cycle between consecutive grants, so a new gnt appears 2 cycles after the eom accept cycle.
- Requests arriving while in GRANT wait; there is no preemption.
- A requester re-asserting req immediately after its own release is served only after the other pending requesters (fairness through last).
- queue_full held high: trmt stays 0 and bytes stay pending. The requester must hold vld/wdata/eom stable until ack.
- busy = (state==GRANT).
- Outputs for requester indices at or beyond NUM_REQ do not exist. No X propagation from unused wdata lanes when gnt=0.

Test Plan:
1. Reset, then req=4'b0001 with 3 bytes 0x41,0x42,0x43 (eom on 0x43), queue_full=0. Required: gnt=0001 one cycle after req; trmt high 3 cycles with tx_data 41,42,43; gnt=0 the cycle after 0x43; busy matches.
2. req=4'b1111 held, each requester sends a 1-byte message (data 0x10+i, eom=1). Required: grant order 0,1,2,3,0; one idle cycle between grants; tx_data sequence 10,11,12,13,10.
3. Requester 2 granted, 2-byte message, queue_full high for 5 cycles mid-message. Required: trmt=0 and ack[2]=0 during the stall; the second byte is written the cycle queue_full drops; no timeout_err.
4. TIMEOUT=8 build; requester 1 granted, vld held 0. Required: timeout_err pulses exactly once 8 cycles after the grant cycle; gnt=0 the next cycle; requester 2 (pending) granted next.
5. Requester 3 drops req mid-message with vld=1. Required: no trmt that cycle; gnt=0 next cycle; last=3, so requester 0 wins if pending.
6. Assert rst_n=0 asynchronously mid-grant with trmt high. Required: gnt, trmt, ack, busy and timeout_err all 0 immediately; after release, requester 0 has priority again.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmit queue among NUM_REQ requesters. A grant covers a
// whole message, so bytes from different requesters never interleave.
// Requesters are served in round-robin order. A watchdog releases a granted
// requester that stops delivering bytes.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req          per-requester request level, held for the whole message
//   vld          per-requester byte valid
//   eom          per-requester end-of-message flag, qualified by vld
//   wdata        packed bytes, requester i on bits [8i+7:8i]
//   gnt          one-hot registered grant
//   ack          per-requester byte accepted this cycle (combinational)
//   timeout_err  one-cycle pulse when the watchdog releases a grant
//   busy         high while a grant is held
//   trmt         write strobe to the UART transmit queue (combinational)
//   tx_data      byte to the UART transmit queue
//   queue_full   UART transmit queue full (backpressure)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   vld,
    input  logic [NUM_REQ-1:0]   eom,
    input  logic [8*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 timeout_err,
    output logic                 busy,
    output logic                 trmt,
    output logic [7:0]           tx_data,
    input  logic                 queue_full
);

    localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [IDX_W-1:0]   owner_reg;   // index of the granted requester
    logic [IDX_W-1:0]   last_reg;    // most recently released requester
    logic [15:0]        wd_cnt_reg;
    logic               timeout_err_reg;

    // Because gnt is one-hot, AND-OR reduction selects the granted lane's
    // controls and byte. Unused lanes are masked to zero, so tx_data is 0
    // (never X) while nothing is granted.
    logic [NUM_REQ-1:0][7:0] lane_masked;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_masked[gi] = wdata[8*gi +: 8] & {8{gnt_reg[gi]}};
        end
    endgenerate

    always_comb begin
        tx_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            tx_data = tx_data | lane_masked[i];
        end
    end

    logic sel_vld, sel_req, sel_eom, accept;

    assign sel_vld = |(gnt_reg & vld);
    assign sel_req = |(gnt_reg & req);
    assign sel_eom = |(gnt_reg & eom);

    // A requester that has dropped req is aborting: its byte is not taken
    // even if vld is still high.
    assign accept = sel_vld & sel_req & ~queue_full;

    assign trmt        = accept;
    assign ack         = gnt_reg & {NUM_REQ{accept}};
    assign gnt         = gnt_reg;
    assign busy        = (state_reg == GRANT);
    assign timeout_err = timeout_err_reg;

    // Round-robin search: first requester with req set, starting just after
    // the last released one and wrapping around.
    logic             winner_found;
    logic [IDX_W-1:0] winner_idx;

    always_comb begin
        int cand;
        winner_found = 1'b0;
        winner_idx   = '0;
        cand         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!winner_found && req[cand]) begin
                winner_found = 1'b1;
                winner_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            gnt_reg         <= '0;
            owner_reg       <= '0;
            last_reg        <= IDX_W'(NUM_REQ - 1);
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    wd_cnt_reg <= '0;
                    if (winner_found) begin
                        state_reg <= GRANT;
                        gnt_reg   <= ONE_HOT_0 << winner_idx;
                        owner_reg <= winner_idx;
                    end
                end
                GRANT: begin
                    if ((accept && sel_eom) || !sel_req) begin
                        // Message complete, or requester aborted.
                        state_reg  <= IDLE;
                        gnt_reg    <= '0;
                        last_reg   <= owner_reg;
                        wd_cnt_reg <= '0;
                    end else if (!accept && (wd_cnt_reg == WD_LAST)) begin
                        state_reg       <= IDLE;
                        gnt_reg         <= '0;
                        last_reg        <= owner_reg;
                        wd_cnt_reg      <= '0;
                        timeout_err_reg <= 1'b1;
                    end else if (accept) begin
                        wd_cnt_reg <= '0;
                    end else begin
                        // Idle and queue_full-stalled cycles both count.
                        wd_cnt_reg <= wd_cnt_reg + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed scenarios followed by a randomized phase. A message-level model
// (current owner index, last released index, idle-cycle count) predicts
// every output each cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   vld = '0;
    logic [N-1:0]   eom = '0;
    logic [8*N-1:0] wdata = '0;
    logic           queue_full = 1'b0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           timeout_err;
    logic           busy;
    logic           trmt;
    logic [7:0]     tx_data;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .vld         (vld),
        .eom         (eom),
        .wdata       (wdata),
        .gnt         (gnt),
        .ack         (ack),
        .timeout_err (timeout_err),
        .busy        (busy),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .queue_full  (queue_full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the queue (-1 = nobody), who was released
    // last, how many cycles the owner has gone without a byte taken.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_idle  = 0;
    bit m_terr  = 1'b0;

    logic [7:0] tx_log[$];
    int         terr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_byte_taken();
        if (m_owner < 0) return 1'b0;
        return vld[m_owner] && req[m_owner] && !queue_full;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_idle  = 0;
        m_terr  = 1'b0;
    endtask

    task automatic model_clock();
        bit taken;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            m_terr = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            m_idle = 0;
        end else begin
            taken  = m_byte_taken();
            m_terr = 1'b0;
            if ((taken && eom[m_owner]) || !req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (!taken && m_idle == TO - 1) begin
                m_last  = m_owner;
                m_owner = -1;
                m_terr  = 1'b1;
            end else begin
                m_idle = taken ? 0 : m_idle + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_gnt;
        logic [7:0]   e_data;
        bit           e_acc;
        e_acc  = m_byte_taken();
        e_gnt  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_data = (m_owner >= 0) ? wdata[8*m_owner +: 8] : 8'h00;
        chk("gnt",         32'(gnt),         32'(e_gnt));
        chk("busy",        32'(busy),        32'(m_owner >= 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("trmt",        32'(trmt),        32'(e_acc));
        chk("ack",         32'(ack),         e_acc ? 32'(e_gnt) : 32'd0);
        chk("tx_data",     32'(tx_data),     32'(e_data));
        if (trmt === 1'b1) tx_log.push_back(tx_data);
        if (timeout_err === 1'b1) terr_seen++;
    endtask

    // One clock: check mid-cycle, then advance model on the edge.
    task automatic step();
        @(negedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic e, input logic [7:0] d);
        vld[i]          = v;
        eom[i]          = e;
        wdata[8*i +: 8] = d;
    endtask

    initial begin
        // ---- 1: reset, then a 3-byte message from requester 0 ----
        do_reset();
        tx_log.delete();
        req = 4'b0001;
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        set_lane(0, 1'b1, 1'b0, 8'h41); step();
        set_lane(0, 1'b1, 1'b0, 8'h42); step();
        set_lane(0, 1'b1, 1'b1, 8'h43); step();
        chk("t1_gnt_off", 32'(gnt), 32'h0);
        chk("t1_busy_off", 32'(busy), 32'h0);
        req = '0; vld = '0; eom = '0;
        step();
        chk("t1_len", tx_log.size(), 3);
        for (int i = 0; i < 3 && i < tx_log.size(); i++)
            chk("t1_byte", 32'(tx_log[i]), 32'h41 + i);

        // ---- 2: all four request single-byte messages ----
        do_reset();
        tx_log.delete();
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 1'b1, 8'(8'h10 + i));
        repeat (10) step();
        req = '0; vld = '0; eom = '0;
        step();
        chk("t2_len", tx_log.size(), 5);
        for (int i = 0; i < 5 && i < tx_log.size(); i++)
            chk("t2_byte", 32'(tx_log[i]), 32'h10 + (i % 4));

        // ---- 3: requester 2, queue_full stall mid-message ----
        tx_log.delete();
        terr_seen = 0;
        req = 4'b0100;
        step();
        chk("t3_gnt", 32'(gnt), 32'h4);
        set_lane(2, 1'b1, 1'b0, 8'h20); step();
        set_lane(2, 1'b1, 1'b1, 8'h21);
        queue_full = 1'b1;
        repeat (5) step();
        queue_full = 1'b0;
        step();
        req = '0; vld = '0; eom = '0;
        step();
        chk("t3_len", tx_log.size(), 2);
        if (tx_log.size() == 2) chk("t3_byte2", 32'(tx_log[1]), 32'h21);
        chk("t3_no_timeout", terr_seen, 0);

        // ---- 4: watchdog releases requester 1, then 2 is served ----
        req = 4'b0010;
        step();
        chk("t4_gnt", 32'(gnt), 32'h2);
        terr_seen = 0;
        req = 4'b0110;
        repeat (8) step();
        chk("t4_terr", 32'(timeout_err), 32'h1);
        chk("t4_gnt_off", 32'(gnt), 32'h0);
        step();
        chk("t4_next", 32'(gnt), 32'h4);
        step();
        chk("t4_one_pulse", terr_seen, 1);
        req = '0;
        step();

        // ---- 5: requester 3 aborts mid-message, 0 wins next ----
        tx_log.delete();
        req = 4'b1001;
        step();
        chk("t5_gnt", 32'(gnt), 32'h8);
        set_lane(3, 1'b1, 1'b0, 8'h30); step();
        req = 4'b0001;
        set_lane(3, 1'b1, 1'b0, 8'h31); step();
        chk("t5_gnt_off", 32'(gnt), 32'h0);
        set_lane(3, 1'b0, 1'b0, 8'h00);
        step();
        chk("t5_next", 32'(gnt), 32'h1);
        chk("t5_len", tx_log.size(), 1);
        set_lane(0, 1'b1, 1'b1, 8'h55); step();
        req = '0; vld = '0; eom = '0;
        step();

        // ---- 6: asynchronous reset while a byte is being written ----
        req = 4'b0010;
        step();
        set_lane(1, 1'b1, 1'b0, 8'h5A);
        #1;
        chk("t6_trmt_pre", 32'(trmt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_gnt",  32'(gnt),         32'h0);
        chk("t6_trmt", 32'(trmt),        32'h0);
        chk("t6_ack",  32'(ack),         32'h0);
        chk("t6_busy", 32'(busy),        32'h0);
        chk("t6_terr", 32'(timeout_err), 32'h0);
        model_reset();
        step();
        rst_n = 1'b1;
        req = 4'b1111; vld = '0; eom = '0;
        step();
        chk("t6_prio", 32'(gnt), 32'h1);
        req = '0;
        step();
        step();

        // ---- randomized traffic ----
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            vld        = N'($urandom);
            eom        = N'($urandom & $urandom);
            wdata      = (8*N)'($urandom);
            queue_full = ($urandom_range(3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
